id_control_hazard_unit: RTL and testbench

Decode-side producer for the ID/EX control interface. It decodes the IF/ID instruction into the control bundle (including the subtract control), detects load-use hazards and EX-resolved branch flushes, and registers the bundle into the ID/EX stage. The EX stage reads the registered outputs directly. Zeroed bundles are inserted as bubbles, and saturating stall and flush event counters are kept for debug.

---
 rtl/id_control_hazard_unit_pkg.sv | 41 ++++
 rtl/id_control_hazard_unit_if.sv | 39 +++
 rtl/id_control_hazard_unit_main_control_decoder.sv | 72 +++++++
 rtl/id_control_hazard_unit.sv | 84 ++++++++
 tb/tb_id_control_hazard_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_control_hazard_unit_pkg.sv
// Shared opcode/funct constants, ALU op codes and the ID/EX control bundle type
// for the decode-side control and hazard unit.
package id_control_hazard_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       sub;
    alu_op_e    alu_op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/id_control_hazard_unit_if.sv
// IF/ID-to-ID/EX control interface: IF/ID inputs, pipeline write enables and
// the registered ID/EX control bundle seen by the EX stage.
interface id_control_hazard_unit_if;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_alu_src;
  logic        ex_reg_dst;
  logic        ex_branch;
  logic        ex_sub;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic        ex_illegal;

  modport master (
    input  if_id_instr, if_id_valid, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush,
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    output ex_alu_src, ex_reg_dst, ex_branch, ex_sub, ex_alu_op,
    output ex_rs, ex_rt, ex_rd, ex_illegal
  );

  modport slave (
    output if_id_instr, if_id_valid, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush,
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    input  ex_alu_src, ex_reg_dst, ex_branch, ex_sub, ex_alu_op,
    input  ex_rs, ex_rt, ex_rd, ex_illegal
  );
endinterface

// File: rtl/id_control_hazard_unit_main_control_decoder.sv
// Purely combinational instruction-to-control-bundle decode, plus a flag
// telling the hazard logic whether the instruction reads rt.
module main_control_decoder
  import id_control_hazard_unit_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic         valid,
  output ctrl_bundle_t ctrl,
  output logic         reads_rt
);

  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic         bad;
  ctrl_bundle_t dec;
  logic         unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];
  assign reads_rt     = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: bad = 1'b1;
        endcase
      end
      OP_LW: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    dec.sub = (dec.alu_op == ALU_SUB) || (dec.alu_op == ALU_SLT);
    dec.rs  = instr[25:21];
    dec.rt  = instr[20:16];
    dec.rd  = instr[15:11];

    // The all-zero word is a canonical NOP even though funct 0 is not listed.
    ctrl = '0;
    if (valid && (instr != 32'd0)) begin
      if (bad) ctrl.illegal = 1'b1;
      else     ctrl = dec;
    end
  end

endmodule

// File: rtl/id_control_hazard_unit.sv
// Decode-side control unit: load-use stall and branch flush detection, ID/EX
// control bundle register and saturating stall/flush event counters.
module id_control_hazard_unit
  import id_control_hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  id_control_hazard_unit_if.master      bus,
  output logic [CNT_W-1:0]              stall_count,
  output logic [CNT_W-1:0]              flush_count
);

  ctrl_bundle_t     dec;
  ctrl_bundle_t     bundle_d, bundle_q;
  logic             reads_rt;
  logic             hazard;
  logic             flush;
  logic [4:0]       id_rs, id_rt;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;
  logic [CNT_W-1:0] flush_count_d, flush_count_q;

  main_control_decoder u_dec (
    .instr    (bus.if_id_instr),
    .valid    (bus.if_id_valid),
    .ctrl     (dec),
    .reads_rt (reads_rt)
  );

  assign id_rs = bus.if_id_instr[25:21];
  assign id_rt = bus.if_id_instr[20:16];

  always_comb begin
    hazard = bus.if_id_valid && bundle_q.mem_read && (bundle_q.rt != 5'd0) &&
             ((bundle_q.rt == id_rs) || (reads_rt && (bundle_q.rt == id_rt)));
    flush  = bus.ex_branch_taken;

    bundle_d      = dec;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    // Flush dominates a coincident hazard: only the flush is counted.
    if (flush) begin
      bundle_d = '0;
      if (flush_count_q != '1) flush_count_d = flush_count_q + 1'b1;
    end else if (hazard) begin
      bundle_d = '0;
      if (stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
    end

    bus.pc_write    = reset || flush || !hazard;
    bus.if_id_write = reset || flush || !hazard;
    bus.if_id_flush = !reset && flush;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bundle_q      <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      bundle_q      <= bundle_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.ex_reg_write  = bundle_q.reg_write;
  assign bus.ex_mem_read   = bundle_q.mem_read;
  assign bus.ex_mem_write  = bundle_q.mem_write;
  assign bus.ex_mem_to_reg = bundle_q.mem_to_reg;
  assign bus.ex_alu_src    = bundle_q.alu_src;
  assign bus.ex_reg_dst    = bundle_q.reg_dst;
  assign bus.ex_branch     = bundle_q.branch;
  assign bus.ex_sub        = bundle_q.sub;
  assign bus.ex_alu_op     = bundle_q.alu_op;
  assign bus.ex_rs         = bundle_q.rs;
  assign bus.ex_rt         = bundle_q.rt;
  assign bus.ex_rd         = bundle_q.rd;
  assign bus.ex_illegal    = bundle_q.illegal;
  assign stall_count       = stall_count_q;
  assign flush_count       = flush_count_q;

endmodule

// File: tb/tb_id_control_hazard_unit.sv
// Directed bench for id_control_hazard_unit: a cycle model built from the
// decode/hazard rules is compared every cycle, plus hand-computed spot checks.
module tb_id_control_hazard_unit;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rw, mr, mw, m2r, as, rdst, br, sub;
    logic [2:0] op;
    logic [4:0] rs, rt, rd;
    logic       ill;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [CNT_W-1:0] stall_count, flush_count;
  id_control_hazard_unit_if bus ();

  int n_checks = 0;
  int n_err    = 0;
  logic chk_en = 1'b0;

  exp_t m_ex    = '0;
  int   m_stall = 0;
  int   m_flush = 0;

  id_control_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.master),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] i, input logic v);
    exp_t e;
    int op, fn, alu;
    e   = '0;
    op  = int'(i[31:26]);
    fn  = int'(i[5:0]);
    alu = -1;
    if (!v || i == 32'd0) return e;
    if (op == 0) begin
      e.rw = 1; e.rdst = 1;
      alu = (fn == 32) ? 0 : (fn == 34) ? 1 : (fn == 36) ? 2 : (fn == 37) ? 3 : (fn == 42) ? 4 : -1;
    end else if (op == 35) begin
      e.mr = 1; e.m2r = 1; e.rw = 1; e.as = 1; alu = 0;
    end else if (op == 43) begin
      e.mw = 1; e.as = 1; alu = 0;
    end else if (op == 4) begin
      e.br = 1; alu = 1;
    end else if (op == 8) begin
      e.rw = 1; e.as = 1; alu = 0;
    end
    if (alu < 0) begin
      e = '0;
      e.ill = 1;
      return e;
    end
    e.op  = alu[2:0];
    e.sub = (alu == 1) || (alu == 4);
    e.rs  = i[25:21];
    e.rt  = i[20:16];
    e.rd  = i[15:11];
    return e;
  endfunction

  function automatic logic ref_hazard(input exp_t ex, input logic [31:0] i, input logic v);
    int op;
    logic uses_rt;
    op = int'(i[31:26]);
    uses_rt = (op == 0) || (op == 43) || (op == 4);
    return v && ex.mr && (ex.rt != 0) && ((ex.rt == i[25:21]) || (uses_rt && ex.rt == i[20:16]));
  endfunction

  // Model state advances on each rising edge using the inputs of the ending cycle.
  always @(posedge clock) begin
    if (reset) begin
      m_ex    <= '0;
      m_stall <= 0;
      m_flush <= 0;
    end else if (bus.ex_branch_taken) begin
      m_ex    <= '0;
      m_flush <= (m_flush < MAXC) ? m_flush + 1 : m_flush;
    end else if (ref_hazard(m_ex, bus.if_id_instr, bus.if_id_valid)) begin
      m_ex    <= '0;
      m_stall <= (m_stall < MAXC) ? m_stall + 1 : m_stall;
    end else begin
      m_ex    <= ref_decode(bus.if_id_instr, bus.if_id_valid);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic haz;
      logic [2:0] en_exp;
      haz    = ref_hazard(m_ex, bus.if_id_instr, bus.if_id_valid);
      en_exp = {reset || bus.ex_branch_taken || !haz,
                reset || bus.ex_branch_taken || !haz,
                !reset && bus.ex_branch_taken};
      check("bundle",
            {37'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg,
             bus.ex_alu_src, bus.ex_reg_dst, bus.ex_branch, bus.ex_sub, bus.ex_alu_op,
             bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_illegal},
            {37'd0, m_ex});
      check("enables", {61'd0, bus.pc_write, bus.if_id_write, bus.if_id_flush}, {61'd0, en_exp});
      check("stall_count", {62'd0, stall_count}, 64'(m_stall));
      check("flush_count", {62'd0, flush_count}, 64'(m_flush));
    end
  end

  task automatic drive(input logic [31:0] instr, input logic v, input logic br, input logic rst);
    bus.if_id_instr     = instr;
    bus.if_id_valid     = v;
    bus.ex_branch_taken = br;
    reset               = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    $display("cycle t=%0t instr=%08h valid=%0b br=%0b rst=%0b", $time,
             bus.if_id_instr, bus.if_id_valid, bus.ex_branch_taken, reset);
    #1;
  endtask

  localparam logic [31:0] I_SUB   = 32'h0109_5022; // sub $10,$8,$9
  localparam logic [31:0] I_ADD   = 32'h0109_5020; // add $10,$8,$9
  localparam logic [31:0] I_SLT   = 32'h0109_502A; // slt $10,$8,$9
  localparam logic [31:0] I_LW8   = 32'h8C28_0000; // lw $8,0($1)
  localparam logic [31:0] I_LW0   = 32'h8C20_0000; // lw $0,0($1)
  localparam logic [31:0] I_ADD38 = 32'h0102_1820; // add $3,$8,$2
  localparam logic [31:0] I_ADD30 = 32'h0002_1820; // add $3,$0,$2
  localparam logic [31:0] I_ADDI  = 32'h2105_0001; // addi $5,$8,1
  localparam logic [31:0] I_ILL   = 32'hFC22_1820; // opcode 0x3F

  initial begin
    drive(I_SUB, 1'b1, 1'b0, 1'b1);
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_pc_write", {63'd0, bus.pc_write}, 64'd1);
    check("rst_ex_reg_write", {63'd0, bus.ex_reg_write}, 64'd0);
    check("rst_stall", {62'd0, stall_count}, 64'd0);

    // Decode sweep: results visible one edge after presentation
    drive(I_SUB, 1'b1, 1'b0, 1'b0);
    check("sub_not_yet", {63'd0, bus.ex_sub}, 64'd0);
    tick();
    check("sub_fields", {50'd0, bus.ex_sub, bus.ex_alu_op, bus.ex_reg_dst, bus.ex_rd, 3'd0},
          {50'd0, 1'b1, 3'd1, 1'b1, 5'd10, 3'd0});
    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    tick();
    check("add_fields", {60'd0, bus.ex_sub, bus.ex_alu_op}, {60'd0, 1'b0, 3'd0});
    drive(I_SLT, 1'b1, 1'b0, 1'b0);
    tick();
    check("slt_fields", {60'd0, bus.ex_sub, bus.ex_alu_op}, {60'd0, 1'b1, 3'd4});

    // Load-use stall
    drive(I_LW8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_ADD38, 1'b1, 1'b0, 1'b0);
    check("lu_stall_en", {62'd0, bus.pc_write, bus.if_id_write}, 64'd0);
    tick();
    check("lu_bubble", {63'd0, bus.ex_reg_write}, 64'd0);
    check("lu_stall_count", {62'd0, stall_count}, 64'd1);
    check("lu_released", {63'd0, bus.pc_write}, 64'd1);
    tick();
    check("lu_add_issued", {59'd0, bus.ex_rd}, 64'd3);

    // No false stall on $0, then stall on rs match for addi
    drive(I_LW0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_ADD30, 1'b1, 1'b0, 1'b0);
    check("zero_no_stall", {63'd0, bus.pc_write}, 64'd1);
    tick();
    drive(I_LW8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_ADDI, 1'b1, 1'b0, 1'b0);
    check("addi_stall", {63'd0, bus.pc_write}, 64'd0);
    tick();
    tick();
    check("addi_issued", {63'd0, bus.ex_alu_src}, 64'd1);

    // Flush wins over a coincident hazard
    drive(I_LW8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_ADD38, 1'b1, 1'b1, 1'b0);
    check("flush_en", {61'd0, bus.if_id_flush, bus.pc_write, bus.if_id_write}, 64'd7);
    tick();
    check("flush_count", {62'd0, flush_count}, 64'd1);
    check("flush_stall_same", {62'd0, stall_count}, 64'd2);

    // Invalid slot with a would-be hazard loads a plain zero bundle
    drive(I_LW8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_ADD38, 1'b0, 1'b0, 1'b0);
    check("invalid_no_stall", {63'd0, bus.pc_write}, 64'd1);
    tick();

    // Illegal opcode, illegal funct, and the all-zero NOP
    drive(I_ILL, 1'b1, 1'b0, 1'b0);
    tick();
    check("illegal_op", {57'd0, bus.ex_illegal, bus.ex_rs, bus.ex_reg_write}, {57'd0, 1'b1, 5'd0, 1'b0});
    drive(32'h0109_5021, 1'b1, 1'b0, 1'b0);
    tick();
    check("illegal_funct", {63'd0, bus.ex_illegal}, 64'd1);
    drive(32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("nop_legal", {63'd0, bus.ex_illegal}, 64'd0);

    // Saturation of the 2-bit stall counter
    for (int k = 0; k < 5; k++) begin
      drive(I_LW8, 1'b1, 1'b0, 1'b0);
      tick();
      drive(I_ADD38, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
    end
    check("stall_saturated", {62'd0, stall_count}, 64'd3);

    // Reset in the middle of a stall
    drive(I_LW8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_ADD38, 1'b1, 1'b0, 1'b1);
    check("rst_mid_stall_en", {63'd0, bus.pc_write}, 64'd1);
    tick();
    check("rst_mid_stall_cnt", {62'd0, stall_count}, 64'd0);
    drive(I_ADD38, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_rst_issue", {59'd0, bus.ex_rd}, 64'd3);
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
